// File: rtl/operand_issue_stage_pkg.sv
// Shared constants for the operand issue stage and its scoreboard.
package operand_issue_stage_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/operand_issue_stage_scoreboard_counters.sv
// Per-register pending-write counters; x0 never counts, and a retire with
// nothing pending latches a sticky error.
module scoreboard_counters
    import operand_issue_stage_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 3
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  inc_valid,
    input  logic [REG_ADDR_W-1:0]                                 inc_rd,
    input  logic                                                  dec_valid,
    input  logic [REG_ADDR_W-1:0]                                 dec_rd,
    output logic [NUM_REGS-1:0]                                   busy,
    output logic [NUM_REGS-1:0][$clog2(MAX_PENDING+1)-1:0]        count,
    output logic                                                  sb_error
);

    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0]    MAX_CNT  = CNT_W'(MAX_PENDING);
    localparam logic [NUM_REGS-1:0] REG_ONE  = NUM_REGS'(1);
    localparam logic [NUM_REGS-1:0] LIVE_MSK = ~REG_ONE;

    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_req;
    logic [NUM_REGS-1:0] dec_hit;

    assign inc_hit = inc_valid ? ((REG_ONE << inc_rd) & LIVE_MSK) : '0;
    assign dec_req = dec_valid ? ((REG_ONE << dec_rd) & LIVE_MSK) : '0;
    assign dec_hit = dec_req & busy;

    always_comb begin
        busy = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy[r] = (count[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            sb_error <= 1'b0;
        end else begin
            // simultaneous issue and retire on the same register cancel out
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (inc_hit[r] && !dec_hit[r] && count[r] != MAX_CNT) begin
                    count[r] <= count[r] + CNT_W'(1);
                end else if (dec_hit[r] && !inc_hit[r]) begin
                    count[r] <= count[r] - CNT_W'(1);
                end
            end
            if (dec_valid && dec_rd != REG_ZERO && !busy[dec_rd]) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_issue_stage.sv
// Decode/issue stage: RAW hazard check against the pending-write scoreboard,
// writeback bypass, and a single valid/ready slot feeding execute.
module operand_issue_stage
    import operand_issue_stage_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned MAX_PENDING = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic                  in_uses_rs1,
    input  logic                  in_uses_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic [REG_ADDR_W-1:0] rf_read_reg1,
    output logic [REG_ADDR_W-1:0] rf_read_reg2,
    input  logic [XLEN-1:0]       rf_read_data1,
    input  logic [XLEN-1:0]       rf_read_data2,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       ex_rs1_val,
    output logic [XLEN-1:0]       ex_rs2_val,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic                  sb_error
);

    localparam int unsigned      CNT_W   = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    logic [NUM_REGS-1:0]            busy;
    logic [NUM_REGS-1:0][CNT_W-1:0] count;
    logic                           wb_hit1, wb_hit2, wb_hit_rd;
    logic                           hazard1, hazard2, structural;
    logic                           accept;
    logic [XLEN-1:0]                rs1_val, rs2_val;

    assign rf_read_reg1 = in_rs1;
    assign rf_read_reg2 = in_rs2;

    assign wb_hit1   = wb_valid && (wb_rd == in_rs1);
    assign wb_hit2   = wb_valid && (wb_rd == in_rs2);
    assign wb_hit_rd = wb_valid && (wb_rd == in_rd);

    always_comb begin
        rs1_val = rf_read_data1;
        if (in_rs1 == REG_ZERO) rs1_val = '0;
        else if (wb_hit1)       rs1_val = wb_data;
        rs2_val = rf_read_data2;
        if (in_rs2 == REG_ZERO) rs2_val = '0;
        else if (wb_hit2)       rs2_val = wb_data;
    end

    // the last outstanding write retiring this cycle is covered by the bypass
    assign hazard1 = in_uses_rs1 && (in_rs1 != REG_ZERO) && busy[in_rs1]
                     && !((count[in_rs1] == CNT_W'(1)) && wb_hit1);
    assign hazard2 = in_uses_rs2 && (in_rs2 != REG_ZERO) && busy[in_rs2]
                     && !((count[in_rs2] == CNT_W'(1)) && wb_hit2);
    assign structural = in_reg_write && (in_rd != REG_ZERO)
                        && (count[in_rd] == MAX_CNT) && !wb_hit_rd;

    assign in_ready = !hazard1 && !hazard2 && !structural && (!ex_valid || ex_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_ctrl      <= '0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
            ex_rd        <= in_rd;
            ex_reg_write <= in_reg_write && (in_rd != REG_ZERO);
            ex_ctrl      <= in_ctrl;
        end else if (ex_ready) begin
            ex_valid     <= 1'b0;
        end
    end

    scoreboard_counters #(
        .MAX_PENDING(MAX_PENDING)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .inc_valid(accept && in_reg_write),
        .inc_rd   (in_rd),
        .dec_valid(wb_valid),
        .dec_rd   (wb_rd),
        .busy     (busy),
        .count    (count),
        .sb_error (sb_error)
    );

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench: stimulus pushes hand-computed slot contents into a queue,
// a negedge monitor pops and compares on every EX handshake.
module tb_operand_issue_stage;
    import operand_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_uses_rs1, in_uses_rs2, in_reg_write;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_read_reg1, rf_read_reg2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [15:0] ex_ctrl;
    logic        sb_error;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [15:0] ctrl;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] rf[32];

    operand_issue_stage #(
        .XLEN(32),
        .CTRL_W(16),
        .MAX_PENDING(3)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_ctrl(in_ctrl),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl),
        .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    assign rf_read_data1 = rf[rf_read_reg1];
    assign rf_read_data2 = rf[rf_read_reg2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + i;
            rf[0] <= 32'h0;
            rf[5] <= 32'h11;
        end else if (wb_valid && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic count_sum(output int s);
        s = 0;
        for (int r = 0; r < 32; r++) s += int'(dut.u_sb.count[r]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL slot_unexpected: got ctrl %h expected no instruction", ex_ctrl);
            end else begin
                mon_e = exp_q.pop_front();
                check("ex_rs1_val", ex_rs1_val, mon_e.rs1);
                check("ex_rs2_val", ex_rs2_val, mon_e.rs2);
                check("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
                check("ex_reg_write", 32'(ex_reg_write), 32'(mon_e.rw));
                check("ex_ctrl", 32'(ex_ctrl), 32'(mon_e.ctrl));
            end
        end
    end

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic [15:0] ctrl,
                         input logic [31:0] e1, input logic [31:0] e2, input logic erw);
        bit accepted = 0;
        in_rs1 = rs1; in_rs2 = rs2; in_uses_rs1 = u1; in_uses_rs2 = u2;
        in_rd = rd; in_reg_write = rw; in_ctrl = ctrl; in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{rs1: e1, rs2: e2, rd: rd, rw: erw, ctrl: ctrl});
                accepted = 1;
            end
        end
        if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got in_ready 0 for ctrl %h expected accept", ctrl);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int s;
        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_rd = '0; in_reg_write = 1'b0;
        in_ctrl = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
        repeat (2) step();
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_ex_rs1_val", ex_rs1_val, 0);
        check("rst_ex_rs2_val", ex_rs2_val, 0);
        check("rst_ex_rd", 32'(ex_rd), 0);
        check("rst_ex_reg_write", 32'(ex_reg_write), 0);
        check("rst_ex_ctrl", 32'(ex_ctrl), 0);
        check("rst_sb_error", 32'(sb_error), 0);
        rst = 1'b0;
        step();
        check("idle_in_ready", 32'(in_ready), 1);

        // plain issue, x0 operand reads as zero
        issue(5'd5, 5'd0, 1, 1, 5'd3, 0, 16'h0001, 32'h11, 32'h0, 0);
        check("t1_ex_valid", 32'(ex_valid), 1);
        check("t1_in_ready", 32'(in_ready), 1);

        // RAW hazard resolved by same-cycle writeback bypass
        issue(5'd1, 5'd2, 1, 1, 5'd7, 1, 16'h0002, 32'h1001, 32'h1002, 1);
        in_rs1 = 5'd7; in_rs2 = 5'd0; in_uses_rs1 = 1; in_uses_rs2 = 0;
        in_rd = 5'd8; in_reg_write = 0; in_ctrl = 16'h0003; in_valid = 1;
        @(negedge clk); check("raw_stall_a", 32'(in_ready), 0);
        @(posedge clk); #1;
        @(negedge clk); check("raw_stall_b", 32'(in_ready), 0);
        @(posedge clk); #1;
        wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hABCD;
        #1 check("raw_bypass_ready", 32'(in_ready), 1);
        issue(5'd7, 5'd0, 1, 0, 5'd8, 0, 16'h0003, 32'hABCD, 32'h0, 0);
        wb_valid = 0;
        check("cnt7_cleared", 32'(dut.u_sb.count[7]), 0);
        step();

        // backpressure: slot stable, then back-to-back drain
        ex_ready = 0;
        issue(5'd3, 5'd4, 1, 1, 5'd0, 0, 16'h00A0, 32'h1003, 32'h1004, 0);
        in_rs1 = 5'd6; in_rs2 = 5'd0; in_uses_rs1 = 1; in_uses_rs2 = 1;
        in_rd = 5'd0; in_reg_write = 0; in_ctrl = 16'h00B0; in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_ex_valid", 32'(ex_valid), 1);
            check("hold_ex_rs1", ex_rs1_val, 32'h1003);
            check("hold_ex_rs2", ex_rs2_val, 32'h1004);
            check("hold_ex_ctrl", 32'(ex_ctrl), 32'h00A0);
        end
        @(posedge clk); #1;
        ex_ready = 1;
        issue(5'd6, 5'd0, 1, 1, 5'd0, 0, 16'h00B0, 32'h1006, 32'h0, 0);
        issue(5'd5, 5'd6, 1, 1, 5'd0, 0, 16'h00C0, 32'h11, 32'h1006, 0);
        step(); step();
        check("drain_queue_empty", 32'(exp_q.size()), 0);

        // structural stall at MAX_PENDING, relieved by same-cycle retire
        for (int k = 0; k < 3; k++)
            issue(5'd0, 5'd0, 0, 0, 5'd9, 1, 16'h0090 + 16'(k), 32'h0, 32'h0, 1);
        check("cnt9_full", 32'(dut.u_sb.count[9]), 3);
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_uses_rs1 = 0; in_uses_rs2 = 0;
        in_rd = 5'd9; in_reg_write = 1; in_ctrl = 16'h0094; in_valid = 1;
        @(negedge clk); check("struct_stall", 32'(in_ready), 0);
        @(posedge clk); #1;
        wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h99;
        issue(5'd0, 5'd0, 0, 0, 5'd9, 1, 16'h0094, 32'h0, 32'h0, 1);
        wb_valid = 0;
        check("cnt9_stays_full", 32'(dut.u_sb.count[9]), 3);
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1; wb_rd = 5'd9;
            step();
            wb_valid = 0;
        end
        check("cnt9_drained", 32'(dut.u_sb.count[9]), 0);
        check("no_error_yet", 32'(sb_error), 0);

        // writeback error handling and rd=0 writes
        wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h55;
        step(); wb_valid = 0;
        check("wb_x0_no_error", 32'(sb_error), 0);
        wb_valid = 1; wb_rd = 5'd12;
        step(); wb_valid = 0;
        check("wb_unpending_error", 32'(sb_error), 1);
        repeat (3) step();
        check("error_sticky", 32'(sb_error), 1);
        issue(5'd0, 5'd0, 0, 0, 5'd0, 1, 16'h00E0, 32'h0, 32'h0, 0);
        step();
        count_sum(s);
        check("rd0_no_count", 32'(s), 0);

        // asynchronous reset while stalled with a full slot
        ex_ready = 0;
        issue(5'd0, 5'd0, 0, 0, 5'd10, 1, 16'h00F0, 32'h0, 32'h0, 1);
        check("cnt10_pending", 32'(dut.u_sb.count[10]), 1);
        in_rs1 = 5'd10; in_rs2 = 5'd0; in_uses_rs1 = 1; in_uses_rs2 = 0;
        in_rd = 5'd0; in_reg_write = 0; in_ctrl = 16'h00F1; in_valid = 1;
        @(negedge clk); check("pre_rst_stall", 32'(in_ready), 0);
        @(posedge clk); #2;
        rst = 1;
        #1;
        check("async_rst_ex_valid", 32'(ex_valid), 0);
        check("async_rst_in_ready", 32'(in_ready), 1);
        check("async_rst_reg_write", 32'(ex_reg_write), 0);
        check("async_rst_sb_error", 32'(sb_error), 0);
        count_sum(s);
        check("async_rst_counts", 32'(s), 0);
        in_valid = 0;
        exp_q.delete();
        step();
        rst = 0; ex_ready = 1;
        step();
        wb_valid = 1; wb_rd = 5'd10;
        step(); wb_valid = 0;
        check("post_rst_wb_error", 32'(sb_error), 1);
        step();
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no finish expected finish by 20000");
        $fatal(1);
    end

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Decode/issue stage sitting directly downstream of the register file read ports and upstream of execute.
- Accepts one decoded instruction per cycle and drives the register-file read addresses.
- Resolves RAW hazards with a per-register pending-write scoreboard, bypasses the same-cycle writeback value, and registers operands into a valid/ready pipeline slot feeding EX.
- Writeback completions return on the wb_* port to retire scoreboard entries.

Parameters:
XLEN, 32, operand/data width
CTRL_W, 16, width of opaque control bundle passed through to EX
MAX_PENDING, 3, max outstanding writes per destination register; counter width is clog2(MAX_PENDING+1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_uses_rs1  in  1  rs1 is a real operand
in_uses_rs2  in  1  rs2 is a real operand
in_rd  in  5  destination register
in_reg_write  in  1  instruction writes rd
in_ctrl  in  CTRL_W  pass-through control
rf_read_reg1  out  5  register-file read address 1, = in_rs1
rf_read_reg2  out  5  register-file read address 2, = in_rs2
rf_read_data1  in  XLEN  combinational read data 1
rf_read_data2  in  XLEN  combinational read data 2
wb_valid  in  1  writeback completes this cycle
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback value, also written to the register file this cycle
ex_valid  out  1  issue slot holds an instruction
ex_ready  in  1  EX consumes slot
ex_rs1_val  out  XLEN  resolved operand 1
ex_rs2_val  out  XLEN  resolved operand 2
ex_rd  out  5  destination register
ex_reg_write  out  1  write-enable for rd
ex_ctrl  out  CTRL_W  control bundle
sb_error  out  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (async, rst=1): all outputs 0, all scoreboard counters 0, sb_error 0. This includes ex_valid, the ex_* data and ex_reg_write. Effective immediately, without waiting for a clock edge.
- Reset mid-operation: the held slot is discarded and all counters are cleared. Later wb_valid pulses then raise sb_error; upstream must flush in lockstep.
- Register-file read addresses are combinational pass-throughs of in_rs1/in_rs2.
- Operand resolution, per source s:
  - s==0 -> 0.
  - Else if wb_valid && wb_rd==s -> wb_data (bypass).
  - Else -> rf_read_data.
- Hazard on source s: uses_s && s!=0 && cnt[s]!=0, unless cnt[s]==1 && wb_valid && wb_rd==s (the last pending write retires this cycle and is bypassed).
- Structural stall: in_reg_write && in_rd!=0 && cnt[in_rd]==MAX_PENDING && !(wb_valid && wb_rd==in_rd).
- in_ready = !hazard1 && !hazard2 && !structural && (!ex_valid || ex_ready). in_ready is combinational and may be asserted without in_valid.
- Accept = in_valid && in_ready. On the accept edge:
  - Slot loads the resolved operands, rd, ctrl, and reg_write masked to 0 when rd==0.
  - ex_valid=1.
  - Latency: accept to ex_valid is 1 cycle.
- ex_valid && ex_ready with no accept: ex_valid falls to 0 next edge; slot data is held, don't care.
- While ex_valid && !ex_ready: all ex_* outputs are stable.
- Scoreboard update per edge, for each register r:
  - +1 if accept with in_reg_write && in_rd==r && r!=0.
  - -1 if wb_valid && wb_rd==r && cnt[r]>0.
  - Both in the same cycle: unchanged.
  - cnt[0] is always 0.
- Writeback with cnt[wb_rd]==0 and wb_rd!=0: no counter change, sb_error sets and stays set until reset.
- Writeback to rd=0: ignored, no error.
- Counters never exceed MAX_PENDING (guaranteed by the structural stall).

Decomposition:
- Shared package: XLEN default, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0.
- Sub-module scoreboard_counters: 32 saturating up/down counters with inc port (valid, rd), dec port (valid, rd), per-register busy/count outputs and sb_error.
- Hazard logic, bypass muxes and the issue slot remain in operand_issue_stage.

Test Plan:
- Reset, then x5 holds 0x11 in the register file; issue rs1=5, rs2=0, uses both -> next cycle ex_valid=1, ex_rs1_val=0x11, ex_rs2_val=0; in_ready stays 1.
- Issue rd=7 reg_write, then rs1=7 consumer -> consumer in_ready=0 while cnt[7]=1. Pulse wb_valid, wb_rd=7, wb_data=0xABCD -> same cycle in_ready=1, next cycle ex_rs1_val=0xABCD, cnt[7]=0.
- Hold ex_ready=0 with slot full -> in_ready=0, ex_* unchanged for 5 cycles. Release -> one slot drain per cycle, no duplicate or lost instruction.
- MAX_PENDING=3: issue three writes to rd=9 -> fourth stalls. Same cycle wb_rd=9 -> fourth accepted and cnt[9] stays 3.
- wb_valid with wb_rd=12 and cnt[12]=0 -> sb_error=1 and remains 1. wb_rd=0 -> no error. Issue with rd=0 reg_write -> ex_reg_write=0, no counter change.
- Assert rst asynchronously mid-stall with ex_valid=1 -> ex_valid=0 and in_ready=1 before the next clock edge; all counters 0.
